// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding and
// forwarding select values, plus the forwarding priority function.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MEM wins over WB; x0 is hardwired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Width-parameterised up-counter with enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush enables, EX forwarding
// selects, multi-cycle freeze FSM with watchdog, and performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             memread_E,
  input  logic             pc_src_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             regwrite_M,
  input  logic             regwrite_W,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  input  logic             mdu_start_E,
  input  logic             mdu_done,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             tmo_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  state_e           state_reg, state_next;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             in_run, in_mem_wait, in_mdu_wait;
  logic             waiting_blocked, tmo_hit;
  logic             mem_freeze, mdu_freeze, load_use;

  assign in_run      = (state_reg == ST_RUN);
  assign in_mem_wait = (state_reg == ST_MEM_WAIT);
  assign in_mdu_wait = (state_reg == ST_MDU_WAIT);

  // The watchdog fires in the cycle the count would reach TMO_CYC, and only
  // if the wait would otherwise continue; a same-cycle ready/done wins.
  assign waiting_blocked = (in_mem_wait && !dmem_ready) || (in_mdu_wait && !mdu_done);
  assign tmo_hit = (TMO_CYC != 0) && waiting_blocked && (tmo_cnt_reg == TMO_LAST);

  assign mem_freeze = ((in_run && dmem_req_M && !dmem_ready) ||
                       (in_mem_wait && !dmem_ready)) && !tmo_hit;
  assign mdu_freeze = !mem_freeze && !tmo_hit &&
                      ((in_run && mdu_start_E && !mdu_done) ||
                       (in_mdu_wait && !mdu_done));

  assign load_use = memread_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (mem_freeze)      state_next = ST_MEM_WAIT;
        else if (mdu_freeze) state_next = ST_MDU_WAIT;
      end
      ST_MEM_WAIT: if (!mem_freeze) state_next = ST_RUN;
      ST_MDU_WAIT: if (!mdu_freeze) state_next = ST_RUN;
      default:     state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (in_run) tmo_cnt_reg <= '0;
      else        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Freezes outrank redirects; a branch held under a freeze acts on release.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    flush_W = 1'b0;
    fwd_a_E = FWD_RF;
    fwd_b_E = FWD_RF;
    tmo_err = 1'b0;
    if (rst_n) begin
      fwd_a_E = fwd_sel(rs1_E, rd_M, regwrite_M, rd_W, regwrite_W);
      fwd_b_E = fwd_sel(rs2_E, rd_M, regwrite_M, rd_W, regwrite_W);
      tmo_err = tmo_hit;
      if (mem_freeze) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (mdu_freeze) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        flush_M = 1'b1;
      end else if (pc_src_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_F),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_D | flush_E),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus freeze,
// timeout and reset sequences, checked through an expected-output queue.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic memread_E, pc_src_E, regwrite_M, regwrite_W;
    logic dmem_req_M, dmem_ready, mdu_start_E, mdu_done;
  } in_t;

  typedef struct packed {
    logic [3:0] stall;   // {F,D,E,M}
    logic [3:0] flush;   // {D,E,M,W}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       tmo;
  } exp_t;

  typedef struct {
    in_t   in;
    exp_t  ex;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic memread_E, pc_src_E, regwrite_M, regwrite_W;
  logic dmem_req_M, dmem_ready, mdu_start_E, mdu_done;
  logic stall_F, stall_D, stall_E, stall_M;
  logic flush_D, flush_E, flush_M, flush_W;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic tmo_err;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;
  int m_stall = 0;
  int m_flush = 0;
  exp_t  sb_q[$];
  string nm_q[$];
  vec_t  vec[13];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32), .TMO_CYC(4), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .memread_E(memread_E), .pc_src_E(pc_src_E),
    .rd_M(rd_M), .rd_W(rd_W), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .mdu_start_E(mdu_start_E), .mdu_done(mdu_done),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .tmo_err(tmo_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic exp_t mk(input logic [3:0] s, input logic [3:0] f,
                              input logic [1:0] a, input logic [1:0] b, input logic t);
    exp_t e;
    e.stall = s; e.flush = f; e.fa = a; e.fb = b; e.tmo = t;
    return e;
  endfunction

  task automatic drive(input in_t v);
    rs1_D = v.rs1_D; rs2_D = v.rs2_D; rs1_E = v.rs1_E; rs2_E = v.rs2_E;
    rd_E = v.rd_E; rd_M = v.rd_M; rd_W = v.rd_W;
    memread_E = v.memread_E; pc_src_E = v.pc_src_E;
    regwrite_M = v.regwrite_M; regwrite_W = v.regwrite_W;
    dmem_req_M = v.dmem_req_M; dmem_ready = v.dmem_ready;
    mdu_start_E = v.mdu_start_E; mdu_done = v.mdu_done;
  endtask

  task automatic cmp(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input state_e exp);
    cmp(nm, "state", 32'(dut.state_reg), 32'(exp));
  endtask

  task automatic check_out();
    exp_t e;
    string nm;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: no expected entry");
      return;
    end
    e  = sb_q.pop_front();
    nm = nm_q.pop_front();
    $display("txn %s stall=%b%b%b%b flush=%b%b%b%b fa=%b fb=%b tmo=%b scnt=%0d fcnt=%0d",
             nm, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
             fwd_a_E, fwd_b_E, tmo_err, stall_cnt, flush_cnt);
    cmp(nm, "stall", {28'd0, stall_F, stall_D, stall_E, stall_M}, {28'd0, e.stall});
    cmp(nm, "flush", {28'd0, flush_D, flush_E, flush_M, flush_W}, {28'd0, e.flush});
    cmp(nm, "fwd_a", {30'd0, fwd_a_E}, {30'd0, e.fa});
    cmp(nm, "fwd_b", {30'd0, fwd_b_E}, {30'd0, e.fb});
    cmp(nm, "tmo_err", {31'd0, tmo_err}, {31'd0, e.tmo});
    cmp(nm, "stall_cnt", stall_cnt, 32'(m_stall));
    cmp(nm, "flush_cnt", flush_cnt, 32'(m_flush));
    m_stall += int'(e.stall[3]);
    m_flush += int'(e.flush[3] | e.flush[2]);
  endtask

  task automatic step(input in_t v, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    drive(v);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    in_t  v;
    exp_t z;
    z = mk(4'b0000, 4'b0000, FWD_RF, FWD_RF, 1'b0);

    for (int i = 0; i < 13; i++) vec[i].in = '0;
    vec[0].name = "idle";        vec[0].ex = z;
    vec[1].name = "lu_rs1";      vec[1].in.memread_E = 1; vec[1].in.rd_E = 5; vec[1].in.rs1_D = 5;
    vec[1].ex = mk(4'b1100, 4'b0100, FWD_RF, FWD_RF, 0);
    vec[2].name = "lu_rs2";      vec[2].in.memread_E = 1; vec[2].in.rd_E = 9; vec[2].in.rs2_D = 9;
    vec[2].ex = mk(4'b1100, 4'b0100, FWD_RF, FWD_RF, 0);
    vec[3].name = "lu_x0";       vec[3].in.memread_E = 1; vec[3].in.rd_E = 0; vec[3].in.rs1_D = 0;
    vec[3].ex = z;
    vec[4].name = "no_load";     vec[4].in.rd_E = 5; vec[4].in.rs1_D = 5;
    vec[4].ex = z;
    vec[5].name = "br_over_lu";  vec[5].in.memread_E = 1; vec[5].in.rd_E = 5; vec[5].in.rs1_D = 5;
    vec[5].in.pc_src_E = 1;      vec[5].ex = mk(4'b0000, 4'b1100, FWD_RF, FWD_RF, 0);
    vec[6].name = "fwd_mem";     vec[6].in.rs1_E = 7; vec[6].in.rs2_E = 7; vec[6].in.rd_M = 7;
    vec[6].in.rd_W = 7; vec[6].in.regwrite_M = 1; vec[6].in.regwrite_W = 1;
    vec[6].ex = mk(4'b0000, 4'b0000, FWD_MEM, FWD_MEM, 0);
    vec[7].name = "fwd_wb";      vec[7].in = vec[6].in; vec[7].in.regwrite_M = 0;
    vec[7].ex = mk(4'b0000, 4'b0000, FWD_WB, FWD_WB, 0);
    vec[8].name = "fwd_x0";      vec[8].in.regwrite_M = 1; vec[8].in.regwrite_W = 1;
    vec[8].ex = z;
    vec[9].name = "fwd_split";   vec[9].in.rs1_E = 3; vec[9].in.rs2_E = 4; vec[9].in.rd_M = 3;
    vec[9].in.rd_W = 4; vec[9].in.regwrite_M = 1; vec[9].in.regwrite_W = 1;
    vec[9].ex = mk(4'b0000, 4'b0000, FWD_MEM, FWD_WB, 0);
    vec[10].name = "fwd_nowr";   vec[10].in.rs1_E = 3; vec[10].in.rd_M = 3;
    vec[10].ex = z;
    vec[11].name = "mdu_fast_br"; vec[11].in.mdu_start_E = 1; vec[11].in.mdu_done = 1;
    vec[11].in.pc_src_E = 1;     vec[11].ex = mk(4'b0000, 4'b1100, FWD_RF, FWD_RF, 0);
    vec[12].name = "mem_fast";   vec[12].in.dmem_req_M = 1; vec[12].in.dmem_ready = 1;
    vec[12].ex = z;

    // Reset holds every enable low even with a load-use and forwarding match present.
    v = vec[1].in; v.rs1_E = 7; v.rd_M = 7; v.regwrite_M = 1;
    drive(v);
    #3;
    cmp("reset", "stall", {28'd0, stall_F, stall_D, stall_E, stall_M}, 32'd0);
    cmp("reset", "flush", {28'd0, flush_D, flush_E, flush_M, flush_W}, 32'd0);
    cmp("reset", "fwd_a", {30'd0, fwd_a_E}, 32'd0);
    cmp("reset", "stall_cnt", stall_cnt, 32'd0);
    chk_state("reset", ST_RUN);
    drive('0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) step(vec[i].in, vec[i].ex, vec[i].name);

    // Memory wait: three frozen cycles, release on ready.
    v = '0; v.dmem_req_M = 1;
    for (int i = 0; i < 3; i++) begin
      step(v, mk(4'b1111, 4'b0001, FWD_RF, FWD_RF, 0), "mem_wait");
      chk_state("mem_wait", (i == 0) ? ST_RUN : ST_MEM_WAIT);
    end
    v.dmem_ready = 1;
    step(v, z, "mem_release");
    step('0, z, "mem_after");
    chk_state("mem_after", ST_RUN);

    // MDU with a branch held in EX across the freeze.
    v = '0; v.mdu_start_E = 1; v.pc_src_E = 1;
    for (int i = 0; i < 4; i++) step(v, mk(4'b1110, 4'b0010, FWD_RF, FWD_RF, 0), "mdu_wait");
    v.mdu_done = 1;
    step(v, mk(4'b0000, 4'b1100, FWD_RF, FWD_RF, 0), "mdu_done_br");
    step('0, z, "mdu_after");
    chk_state("mdu_after", ST_RUN);

    // Memory priority over a simultaneous mul/div start.
    v = '0; v.dmem_req_M = 1; v.mdu_start_E = 1;
    step(v, mk(4'b1111, 4'b0001, FWD_RF, FWD_RF, 0), "mem_over_mdu");
    v.dmem_ready = 1;
    step(v, z, "mem_over_mdu_rel");
    v = '0; v.mdu_start_E = 1; v.mdu_done = 1;
    step(v, z, "mdu_reeval_done");

    // Watchdog: TMO_CYC=4, ready never arrives.
    v = '0; v.dmem_req_M = 1;
    for (int i = 0; i < 4; i++) step(v, mk(4'b1111, 4'b0001, FWD_RF, FWD_RF, 0), "tmo_wait");
    step(v, mk(4'b0000, 4'b0000, FWD_RF, FWD_RF, 1), "tmo_pulse");
    step('0, z, "tmo_after");
    chk_state("tmo_after", ST_RUN);

    // Asynchronous reset in the middle of an MDU wait.
    v = '0; v.mdu_start_E = 1;
    step(v, mk(4'b1110, 4'b0010, FWD_RF, FWD_RF, 0), "mdu_pre_rst");
    step(v, mk(4'b1110, 4'b0010, FWD_RF, FWD_RF, 0), "mdu_pre_rst");
    chk_state("mdu_pre_rst", ST_MDU_WAIT);
    @(posedge clk);
    #1;
    v.rs1_E = 7; v.rd_M = 7; v.regwrite_M = 1;
    drive(v);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("mid_rst", "stall", {28'd0, stall_F, stall_D, stall_E, stall_M}, 32'd0);
    cmp("mid_rst", "flush", {28'd0, flush_D, flush_E, flush_M, flush_W}, 32'd0);
    cmp("mid_rst", "fwd_a", {30'd0, fwd_a_E}, 32'd0);
    cmp("mid_rst", "stall_cnt", stall_cnt, 32'd0);
    cmp("mid_rst", "flush_cnt", flush_cnt, 32'd0);
    chk_state("mid_rst", ST_RUN);
    drive('0);
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(vec[1].in, vec[1].ex, "post_rst_lu");
    step('0, z, "post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
